fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, giving the data word width in bits.
REQ-002 The block SHALL have port rclk, input, 1 bit: the single clock, the FIFO read-domain clock.
REQ-003 The block SHALL have port rrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port rempty, input, 1 bit: FIFO empty flag.
REQ-005 The block SHALL have port rdata, input, DSIZE bits: FIFO head word, valid combinationally whenever rempty=0.
REQ-006 The block SHALL have port rinc, output, 1 bit: FIFO pop strobe; one word is consumed per rclk edge while high.
REQ-007 The block SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-008 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-009 The block SHALL have port m_data, output, DSIZE bits: stream data.
REQ-010 The block SHALL have port rd_count, output, 16 bits: accepted-word counter; the port exists only under FIFO_RD_STREAM_CNT_EN.

Function
REQ-011 The block SHALL hold a 2-entry register buffer (head, skid) with state EMPTY (0 words), ONE (1 word) or TWO (2 words).
REQ-012 rinc SHALL equal (rempty=0) AND (state≠TWO), with no combinational path from m_ready to rinc.
REQ-013 When rinc=1, rdata SHALL be captured at that rclk edge: into head if head is empty after any pop this cycle, otherwise into skid.
REQ-014 m_valid SHALL equal (state≠EMPTY), and m_data SHALL be driven directly from the head register.
REQ-015 A transfer SHALL occur when m_valid=1 and m_ready=1; skid then moves to head on the same edge when state=TWO.
REQ-016 State transitions with push=rinc and pop=transfer:
- EMPTY: push → ONE.
- ONE: push&!pop → TWO; !push&pop → EMPTY; push&pop → ONE (head replaced by rdata).
- TWO: pop → ONE (push is impossible in TWO).
REQ-017 The block SHALL sustain one word per cycle in state ONE with rempty=0 and m_ready=1 held high.
REQ-018 Latency SHALL be 1 cycle: a word popped at edge N is visible on m_data after edge N.
REQ-019 While m_valid=1 and m_ready=0, m_data SHALL hold stable, and words SHALL be delivered in FIFO order with no loss or duplication.
REQ-020 rempty rising in any state SHALL only stop pushes; buffered words SHALL still drain.

Reset
REQ-021 While rrst_n=0, the block SHALL force state=EMPTY, m_valid=0, rinc=0, head/skid=0 and rd_count=0, asynchronously.
REQ-022 Reset mid-operation SHALL discard buffered words, and rinc SHALL not assert until after the first rclk edge following deassertion.

Configuration
REQ-023 With FIFO_RD_STREAM_CNT_EN defined, rd_count SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-024 Without FIFO_RD_STREAM_CNT_EN, the rd_count port and its register SHALL be absent, with all other behaviour identical.

Structure
REQ-025 Package fifo_pkg SHALL hold the default DSIZE, the buffer-state enum (EMPTY, ONE, TWO), and CNT_W=16.
REQ-026 The block SHALL have no sub-module; the skid buffer is inline, as it is small and tied to the rinc rule.

Verification
REQ-027 Reset: hold rrst_n=0 with rempty=0 → rinc=0, m_valid=0 and rd_count=0; after release, rinc=1 on the first cycle.
REQ-028 Streaming: FIFO supplies 0x01..0x10, m_ready=1 constantly → 16 consecutive transfers in order, rinc never low while data is present, rd_count=16.
REQ-029 Backpressure: m_ready=0 with 5 words available → exactly 2 pops, then rinc=0, m_data=first word stable; m_ready=1 → words delivered in order 1..5.
REQ-030 Empty boundary: a single word 0xA5 followed by rempty=1 → one transfer of 0xA5, then m_valid=0, with no spurious pop while rempty=1.
REQ-031 Random m_ready (50%) against random rempty, 1000 words → scoreboard matches exactly, with no m_data change while m_valid=1 and m_ready=0.
REQ-032 Counter wrap (CNT_EN): preload by 65535 transfers, then one more → rd_count=0x0000; without the macro, elaboration succeeds with no rd_count port.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   DSIZE_DEF   : default data word width
//   CNT_W       : width of the optional accepted-word counter
//   buf_state_e : occupancy of the two-entry head/skid buffer
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    Empty = 2'd0,
    One   = 2'd1,
    Two   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter.
//
// Pops words from an asynchronous FIFO read port (rempty/rdata/rinc) into a two-entry
// head/skid register buffer and presents them as a valid/ready stream. The pop strobe
// depends only on registered state and rempty, so m_ready never reaches rinc
// combinationally; the skid entry absorbs the word already in flight when the
// downstream stalls.
//
// Ports:
//   rclk      in   read-domain clock
//   rrst_n    in   asynchronous active-low reset
//   rempty    in   FIFO empty flag
//   rdata     in   FIFO head word, valid while rempty=0
//   rinc      out  FIFO pop strobe
//   m_valid   out  stream valid
//   m_ready   in   stream accept
//   m_data    out  stream data, driven from the head register
//   rd_count  out  accepted-word counter (only with FIFO_RD_STREAM_CNT_EN)
//
// Build option: define FIFO_RD_STREAM_CNT_EN to add the rd_count port and counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  buf_state_e       state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  // Holds rinc low until the first clock edge after reset release.
  logic             arm_q;

  logic push;
  logic pop;

  assign rinc    = arm_q & ~rempty & (state_q != Two);
  assign m_valid = (state_q != Empty);
  assign m_data  = head_q;

  assign push = rinc;
  assign pop  = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      Empty: begin
        if (push) begin
          head_d  = rdata;
          state_d = One;
        end
      end
      One: begin
        if (push && pop) begin
          // Head leaves and is refilled on the same edge.
          head_d = rdata;
        end else if (push) begin
          skid_d  = rdata;
          state_d = Two;
        end else if (pop) begin
          state_d = Empty;
        end
      end
      Two: begin
        // rinc is low in Two, so only a pop can occur here.
        if (pop) begin
          head_d  = skid_q;
          state_d = One;
        end
      end
      default: begin
        state_d = Empty;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= Empty;
      head_q  <= '0;
      skid_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      arm_q   <= 1'b1;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + random bench for fifo_rd_stream. A behavioural FIFO feeds the read port;
// every word loaded into it is pushed to a scoreboard queue and popped/compared when
// the stream side accepts it.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] rd_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [2048];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  bit            hold_empty = 1'b0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_w;
  logic [15:0]   exp_cnt = 16'd0;
  int            xfers = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_rd_stream #(
    .DSIZE(DW)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  // Behavioural FIFO read port.
  assign rempty = hold_empty || (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr % 2048];

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  // Stream-side scoreboard and protocol checks, sampled mid-cycle.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_stall = 1'b0;
      exp_cnt    = 16'd0;
    end else begin
      total++;
      assert (!(rinc && rempty)) else begin
        bad++;
        $error("FAIL pop_while_empty rinc=%0b required=0 (rempty=1)", rinc);
      end
      if (prev_stall && m_valid) begin
        total++;
        assert (m_data === prev_data) else begin
          bad++;
          $error("FAIL stall_stable got=%0h required=%0h", m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_xfer got=%0h required=no transfer", m_data);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          total++;
          assert (m_data === exp_w) else begin
            bad++;
            $error("FAIL xfer_data got=%0h required=%0h", m_data, exp_w);
          end
        end
`ifdef FIFO_RD_STREAM_CNT_EN
        total++;
        assert (rd_count === exp_cnt) else begin
          bad++;
          $error("FAIL xfer_count got=%0h required=%0h", rd_count, exp_cnt);
        end
`endif
        exp_cnt = exp_cnt + 16'd1;
        xfers++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic put(input logic [DW-1:0] w);
    mem[wr_ptr % 2048] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
    total++;
    assert (got === req) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, got, req);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL timeout got=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r0;
    int x0;

    // Reset with data already waiting in the FIFO.
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) put(i[DW-1:0]);
    repeat (3) step();
    check("rst_rinc", rinc, 0);
    check("rst_valid", m_valid, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("rst_count", rd_count, 0);
`endif
    rrst_n = 1'b1;
    #1;
    check("rinc_before_edge", rinc, 0);
    x0 = xfers;
    step();
    check("rinc_first_cycle", rinc, 1);

    // Streaming 0x01..0x10 with m_ready held high.
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (rd_ptr != wr_ptr) check("stream_rinc", rinc, 1);
      step();
      n++;
    end
    check("stream_cycles", n, 17);
    check("stream_xfers", xfers - x0, 16);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("stream_count", rd_count, 16);
`endif
    step();
    check("stream_idle_valid", m_valid, 0);

    // Backpressure: only two words may be pulled while stalled.
    m_ready = 1'b0;
    r0 = rd_ptr;
    for (int i = 1; i <= 5; i++) put(8'h20 + i[DW-1:0]);
    repeat (6) step();
    check("bp_pops", rd_ptr - r0, 2);
    check("bp_rinc", rinc, 0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 8'h21);
    m_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Single word then empty FIFO.
    step();
    put(8'hA5);
    wait_drain("empty_drain", 20);
    repeat (3) step();
    check("empty_valid", m_valid, 0);
    check("empty_rinc", rinc, 0);
    check("empty_no_extra_pop", rd_ptr, wr_ptr);

    // Random ready and random empty gaps.
    x0 = xfers;
    for (int i = 0; i < 1000; i++) put($urandom_range(0, 255));
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      m_ready    = ($urandom_range(0, 1) == 1);
      hold_empty = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    m_ready    = 1'b1;
    hold_empty = 1'b0;
    check("rand_drain", exp_q.size(), 0);
    check("rand_xfers", xfers - x0, 1000);
    repeat (3) step();

    // Reset with two words buffered: they are lost, the third survives in the FIFO.
    m_ready = 1'b0;
    put(8'h31);
    put(8'h32);
    put(8'h33);
    repeat (3) step();
    #2;
    rrst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_rinc", rinc, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("midrst_count", rd_count, 0);
`endif
    n = exp_q.size() - (wr_ptr - rd_ptr);
    check("midrst_buffered", n, 2);
    repeat (n) void'(exp_q.pop_front());
    repeat (2) step();
    rrst_n = 1'b1;
    #1;
    check("midrst_rinc_release", rinc, 0);
    m_ready = 1'b1;
    wait_drain("midrst_drain", 20);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap: run the count up to 0xFFFF, then one more transfer.
    n = 0;
    while (exp_cnt != 16'hFFFF && n < 70000) begin
      if (wr_ptr - rd_ptr < 8) put(n[DW-1:0]);
      step();
      if (exp_cnt == 16'hFFFF) m_ready = 1'b0;
      n++;
    end
    m_ready = 1'b0;
    check("wrap_pre", rd_count, 16'hFFFF);
    check("wrap_valid", m_valid, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("wrap_zero", rd_count, 16'h0000);
    m_ready = 1'b1;
    wait_drain("wrap_drain", 40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
